// File: rtl/fft_bfly_seq_pkg.sv
// ---- fft_bfly_seq_pkg : shared state encoding and default sizing ----
// ---- rev 1.0 ----
`default_nettype none

package fft_bfly_seq_pkg;

  localparam int DEF_MEMWIDTH  = 128;
  localparam int DEF_WORDWIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_CAP    = 3'd2,
    S_WA     = 3'd3,
    S_WB     = 3'd4,
    S_DRAIN0 = 3'd5,
    S_DRAIN1 = 3'd6,
    S_DONE   = 3'd7
  } fft_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/fft_bfly_seq_if.sv
// ---- fft_bfly_seq_if : pair-read / single-write bus to the FFT memory ----
// ---- rev 1.0 ----
`default_nettype none

interface fft_bfly_seq_if #(
  parameter int WORDWIDTH = 16
);
  logic [WORDWIDTH-1:0] mem_addr_o;
  logic                 mem_rd_en_o;
  logic                 mem_wr_en_o;
  logic [WORDWIDTH-1:0] mem_wdata_o;
  logic [WORDWIDTH-1:0] mem_rdata_a_i;
  logic [WORDWIDTH-1:0] mem_rdata_b_i;

  modport master (
    output mem_addr_o, mem_rd_en_o, mem_wr_en_o, mem_wdata_o,
    input  mem_rdata_a_i, mem_rdata_b_i
  );

  modport slave (
    input  mem_addr_o, mem_rd_en_o, mem_wr_en_o, mem_wdata_o,
    output mem_rdata_a_i, mem_rdata_b_i
  );
endinterface

`default_nettype wire

// File: rtl/fft_bfly_seq_alu.sv
// ---- fft_bfly_alu : combinational radix-2 butterfly with scale or saturate ----
// ---- rev 1.0 ----
`default_nettype none

module fft_bfly_alu #(
  parameter int WORDWIDTH = 16
) (
  input  logic [WORDWIDTH-1:0] a,
  input  logic [WORDWIDTH-1:0] b,
  input  logic                 scale,
  output logic [WORDWIDTH-1:0] sum,
  output logic [WORDWIDTH-1:0] diff,
  output logic                 sat_sum,
  output logic                 sat_diff
);

  localparam logic signed [WORDWIDTH:0] MAXV = {2'b00, {(WORDWIDTH-1){1'b1}}};
  localparam logic signed [WORDWIDTH:0] MINV = {2'b11, {(WORDWIDTH-1){1'b0}}};

  logic signed [WORDWIDTH:0] ext_sum;
  logic signed [WORDWIDTH:0] ext_diff;

  assign ext_sum  = $signed({a[WORDWIDTH-1], a}) + $signed({b[WORDWIDTH-1], b});
  assign ext_diff = $signed({a[WORDWIDTH-1], a}) - $signed({b[WORDWIDTH-1], b});

  // Returns {saturated_flag, result}; the extra bit makes the >>>1 result always fit.
  function automatic logic [WORDWIDTH:0] shape(input logic signed [WORDWIDTH:0] v,
                                               input logic sc);
    if (sc)
      shape = {1'b0, v[WORDWIDTH:1]};
    else if (v > MAXV)
      shape = {1'b1, MAXV[WORDWIDTH-1:0]};
    else if (v < MINV)
      shape = {1'b1, MINV[WORDWIDTH-1:0]};
    else
      shape = {1'b0, v[WORDWIDTH-1:0]};
  endfunction

  assign {sat_sum, sum}   = shape(ext_sum, scale);
  assign {sat_diff, diff} = shape(ext_diff, scale);

endmodule

`default_nettype wire

// File: rtl/fft_bfly_seq.sv
// ---- fft_bfly_seq : in-place radix-2 butterfly sequencer over the FFT memory ----
// ---- rev 1.0 ----
`default_nettype none

module fft_bfly_seq
  import fft_bfly_seq_pkg::*;
#(
  parameter int MEMWIDTH  = DEF_MEMWIDTH,
  parameter int WORDWIDTH = DEF_WORDWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [WORDWIDTH-1:0] base_i,
  input  logic [WORDWIDTH-1:0] npairs_i,
  input  logic                 scale_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [WORDWIDTH-1:0] sat_cnt_o,
  fft_bfly_seq_if.master       mem
);

  localparam logic [WORDWIDTH:0]   LAST_ADDR = (WORDWIDTH+1)'(MEMWIDTH - 1);
  localparam logic [WORDWIDTH-1:0] ONE       = WORDWIDTH'(1);
  localparam logic [WORDWIDTH-1:0] TWO       = WORDWIDTH'(2);

  fft_seq_state_t state, state_nxt;

  logic [WORDWIDTH-1:0] addr;
  logic [WORDWIDTH-1:0] remain;
  logic [WORDWIDTH-1:0] cap_a;
  logic [WORDWIDTH-1:0] cap_b;
  logic [WORDWIDTH-1:0] sat_cnt;
  logic                 scale;
  logic                 err;

  logic [WORDWIDTH:0]   addr_p1;
  logic                 oob;
  logic [WORDWIDTH-1:0] sum, diff;
  logic                 sat_sum, sat_diff;

  // Widened by one bit so an address near the top of the word range cannot wrap.
  assign addr_p1 = {1'b0, addr} + {{WORDWIDTH{1'b0}}, 1'b1};
  assign oob     = addr_p1 > LAST_ADDR;

  fft_bfly_alu #(
    .WORDWIDTH (WORDWIDTH)
  ) u_alu (
    .a        (cap_a),
    .b        (cap_b),
    .scale    (scale),
    .sum      (sum),
    .diff     (diff),
    .sat_sum  (sat_sum),
    .sat_diff (sat_diff)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr    <= '0;
      remain  <= '0;
      cap_a   <= '0;
      cap_b   <= '0;
      sat_cnt <= '0;
      scale   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            addr    <= {base_i[WORDWIDTH-1:1], 1'b0};
            remain  <= npairs_i;
            scale   <= scale_i;
            sat_cnt <= '0;
            err     <= 1'b0;
          end
        end
        S_RD: begin
          if (oob && !abort_i)
            err <= 1'b1;
        end
        S_CAP: begin
          cap_a <= mem.mem_rdata_a_i;
          cap_b <= mem.mem_rdata_b_i;
        end
        S_WA: begin
          if (sat_sum && (sat_cnt != '1))
            sat_cnt <= sat_cnt + ONE;
        end
        S_WB: begin
          if (sat_diff && (sat_cnt != '1))
            sat_cnt <= sat_cnt + ONE;
          remain <= remain - ONE;
          addr   <= addr + TWO;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt       = state;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    mem.mem_addr_o  = '0;
    mem.mem_rd_en_o = 1'b0;
    mem.mem_wr_en_o = 1'b0;
    mem.mem_wdata_o = '0;

    case (state)
      S_IDLE: begin
        if (start_i)
          state_nxt = (npairs_i == '0) ? S_DONE : S_RD;
      end
      S_RD: begin
        busy_o = 1'b1;
        if (oob) begin
          state_nxt = S_DONE;
        end else begin
          mem.mem_addr_o  = addr;
          mem.mem_rd_en_o = 1'b1;
          state_nxt       = S_CAP;
        end
      end
      S_CAP: begin
        busy_o          = 1'b1;
        mem.mem_addr_o  = addr;
        mem.mem_rd_en_o = 1'b1;
        state_nxt       = S_WA;
      end
      S_WA: begin
        busy_o          = 1'b1;
        mem.mem_addr_o  = addr;
        mem.mem_wr_en_o = 1'b1;
        mem.mem_wdata_o = sum;
        state_nxt       = S_WB;
      end
      S_WB: begin
        busy_o          = 1'b1;
        mem.mem_addr_o  = addr_p1[WORDWIDTH-1:0];
        mem.mem_wr_en_o = 1'b1;
        mem.mem_wdata_o = diff;
        state_nxt       = (remain != ONE) ? S_RD : S_DRAIN0;
      end
      S_DRAIN0: begin
        busy_o    = 1'b1;
        state_nxt = S_DRAIN1;
      end
      S_DRAIN1: begin
        busy_o    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (abort_i && (state != S_IDLE))
      state_nxt = S_IDLE;
  end

  assign err_o     = err;
  assign sat_cnt_o = sat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fft_bfly_seq.sv
// ---- tb_fft_bfly_seq : directed and randomized checks against a memory-level model ----
// ---- rev 1.0 ----
`default_nettype none

module tb_fft_bfly_seq;
  import fft_bfly_seq_pkg::*;

  localparam int MW = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [15:0] base_i = '0;
  logic [15:0] npairs_i = '0;
  logic        scale_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [15:0] sat_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] mem     [MW];
  logic [15:0] ref_mem [MW];

  fft_bfly_seq_if #(.WORDWIDTH(16)) bus ();

  fft_bfly_seq #(.MEMWIDTH(MW), .WORDWIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .base_i    (base_i),
    .npairs_i  (npairs_i),
    .scale_i   (scale_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .sat_cnt_o (sat_cnt_o),
    .mem       (bus.master)
  );

  always #5 clk = ~clk;

  // Pair-read memory: registered outputs, zero when not enabled.
  always @(posedge clk) begin
    if (bus.mem_wr_en_o && int'(bus.mem_addr_o) < MW)
      mem[int'(bus.mem_addr_o)] = bus.mem_wdata_o;
    if (bus.mem_rd_en_o && int'(bus.mem_addr_o) < MW - 1) begin
      bus.mem_rdata_a_i <= mem[int'(bus.mem_addr_o)];
      bus.mem_rdata_b_i <= mem[int'(bus.mem_addr_o) + 1];
    end else begin
      bus.mem_rdata_a_i <= '0;
      bus.mem_rdata_b_i <= '0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"},  32'(busy_o), 0);
    check({tag, ".done"},  32'(done_o), 0);
    check({tag, ".err"},   32'(err_o), 0);
    check({tag, ".sat"},   32'(sat_cnt_o), 0);
    check({tag, ".addr"},  32'(bus.mem_addr_o), 0);
    check({tag, ".rd"},    32'(bus.mem_rd_en_o), 0);
    check({tag, ".wr"},    32'(bus.mem_wr_en_o), 0);
    check({tag, ".wdata"}, 32'(bus.mem_wdata_o), 0);
  endtask

  task automatic shape(input int v, input int sc, inout int cnt, output logic [15:0] r);
    int t;
    if (sc != 0) t = v >>> 1;
    else if (v > 32767) begin t = 32767; cnt++; end
    else if (v < -32768) begin t = -32768; cnt++; end
    else t = v;
    r = t[15:0];
  endtask

  // Whole-run model: updates ref_mem and predicts flags and timing.
  task automatic model(input int base, input int n, input int sc,
                       output int e_sat, output int e_err, output int e_done);
    int ad, a, b;
    logic [15:0] r;
    e_sat  = 0;
    e_err  = 0;
    e_done = (n == 0) ? 1 : 4 * n + 3;
    for (int k = 0; k < n; k++) begin
      ad = (base & ~1) + 2 * k;
      if (ad + 1 > MW - 1) begin
        e_err  = 1;
        e_done = 4 * k + 2;
        break;
      end
      a = int'($signed(ref_mem[ad]));
      b = int'($signed(ref_mem[ad + 1]));
      shape(a + b, sc, e_sat, r); ref_mem[ad] = r;
      shape(a - b, sc, e_sat, r); ref_mem[ad + 1] = r;
    end
  endtask

  task automatic run(input logic [15:0] base, input logic [15:0] n, input logic sc,
                     input int abort_at, output int done_cyc, output int done_cnt,
                     output int busy_cnt);
    done_cyc = -1;
    done_cnt = 0;
    busy_cnt = 0;
    @(negedge clk);
    start_i = 1'b1; base_i = base; npairs_i = n; scale_i = sc;
    @(posedge clk);
    #1 start_i = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      abort_i = (c == abort_at);
      if (done_o) begin done_cyc = c; done_cnt++; end
      if (busy_o) busy_cnt++;
      if (c > 1 && !busy_o && !done_o && !abort_i) break;
    end
    abort_i = 1'b0;
  endtask

  task automatic full_run(input string tag, input logic [15:0] base, input logic [15:0] n,
                          input logic sc);
    int e_sat, e_err, e_done, dc, dn, bc, bad;
    ref_mem = mem;
    model(int'(base), int'(n), int'(sc), e_sat, e_err, e_done);
    run(base, n, sc, 0, dc, dn, bc);
    check({tag, ".done_cycle"}, dc, e_done);
    check({tag, ".done_count"}, dn, 1);
    check({tag, ".busy_cycles"}, bc, e_done - 1);
    check({tag, ".sat_cnt"}, 32'(sat_cnt_o), e_sat);
    check({tag, ".err"}, 32'(err_o), e_err);
    bad = 0;
    for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) bad++;
    check({tag, ".mem_words_wrong"}, bad, 0);
  endtask

  initial begin
    int dc, dn, bc;
    for (int i = 0; i < MW; i++) mem[i] = 16'(i * 3 + 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_active");
    rst = 1'b0;
    @(negedge clk);
    check_quiet("after_reset");

    mem[0] = 16'd100; mem[1] = 16'd20;
    full_run("basic", 16'd0, 16'd1, 1'b0);
    check("basic.mem0", 32'(mem[0]), 120);
    check("basic.mem1", 32'(mem[1]), 80);

    mem[2] = 16'h7FFF; mem[3] = 16'h0001;
    full_run("sat_pos", 16'd2, 16'd1, 1'b0);
    check("sat_pos.mem2", 32'(mem[2]), 32'h7FFF);
    check("sat_pos.mem3", 32'(mem[3]), 32'h7FFE);
    check("sat_pos.sat", 32'(sat_cnt_o), 1);

    mem[2] = 16'h7FFF; mem[3] = 16'h0001;
    full_run("scaled", 16'd3, 16'd1, 1'b1);
    check("scaled.mem2", 32'(mem[2]), 32'h4000);
    check("scaled.mem3", 32'(mem[3]), 32'h3FFF);

    mem[0] = 16'h8000; mem[1] = 16'h0001;
    full_run("sat_neg", 16'd0, 16'd1, 1'b0);
    check("sat_neg.mem0", 32'(mem[0]), 32'h8001);
    check("sat_neg.mem1", 32'(mem[1]), 32'h8000);

    full_run("range_err", 16'd124, 16'd4, 1'b0);
    check("range_err.err", 32'(err_o), 1);

    full_run("zero_pairs", 16'd10, 16'd0, 1'b0);

    // Abort during pair 2's capture cycle: pairs 0-1 land, pair 2 stays.
    for (int i = 0; i < MW; i++) mem[i] = 16'($urandom);
    begin
      int e_sat, e_err, e_done, bad;
      ref_mem = mem;
      model(0, 2, 0, e_sat, e_err, e_done);
      run(16'd0, 16'd8, 1'b0, 10, dc, dn, bc);
      check("abort.done_count", dn, 0);
      check("abort.busy_cycles", bc, 10);
      check("abort.sat", 32'(sat_cnt_o), e_sat);
      bad = 0;
      for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) bad++;
      check("abort.mem_words_wrong", bad, 0);
    end

    // Reset in the middle of a run.
    @(negedge clk);
    start_i = 1'b1; base_i = 16'd0; npairs_i = 16'd8; scale_i = 1'b0;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("mid_reset");
    rst = 1'b0;

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < MW; i++) mem[i] = 16'($urandom);
      if (t % 4 == 0) begin
        mem[2 * t] = 16'h7000 | 16'($urandom_range(0, 4095));
        mem[2 * t + 1] = 16'h7000;
      end
      full_run($sformatf("rand%0d", t), 16'($urandom_range(0, MW - 1)),
               16'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
